// File: rtl/sram_arb_pkg.sv
// Purpose: shared types and constants for the SRAM arbiter (FSM states, owner codes, default widths).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_arb_pkg;

  localparam int ADDR_W_DEF = 19;
  localparam int DATA_W_DEF = 16;

  // Owner tag carried alongside a read so the returning data reaches the right client.
  localparam logic OWN_VID  = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    TURN   = 2'd2
  } state_e;

endpackage

// File: rtl/sram_arb_return.sv
// Purpose: read-return path; pipes owner tag + valid for two cycles, captures pad data and routes it.
// Latency: issue in cycle N -> rvalid/rdata registered for cycle N+2.
// Backpressure: none; returns are pulses, clients must accept them.
// Ports: clk_core_i/reset_i; issue_rd_i/issue_own_i mark a read granted this cycle;
//   sram_rdata_i is pad data during the access cycle; *_rvalid_o/*_rdata_o are the routed returns.
module sram_arb_return
  import sram_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_core_i,
  input  logic              reset_i,
  input  logic              issue_rd_i,
  input  logic              issue_own_i,
  input  logic [DATA_W-1:0] sram_rdata_i,
  output logic              vid_rvalid_o,
  output logic [DATA_W-1:0] vid_rdata_o,
  output logic              host_rvalid_o,
  output logic [DATA_W-1:0] host_rdata_o
);

  // Stage 1: the read is on the SRAM pins during this stage.
  logic              rd_vld_q, rd_vld_d;
  logic              rd_own_q, rd_own_d;
  // Stage 2: captured data presented to the owner.
  logic              vid_rvalid_q, vid_rvalid_d;
  logic              host_rvalid_q, host_rvalid_d;
  logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

  always_comb begin
    rd_vld_d      = issue_rd_i;
    rd_own_d      = issue_own_i;
    vid_rvalid_d  = rd_vld_q && (rd_own_q == OWN_VID);
    host_rvalid_d = rd_vld_q && (rd_own_q == OWN_HOST);
    // Data registers only load on their own valid so they hold between returns.
    vid_rdata_d   = vid_rvalid_d  ? sram_rdata_i : vid_rdata_q;
    host_rdata_d  = host_rvalid_d ? sram_rdata_i : host_rdata_q;
  end

  always_ff @(posedge clk_core_i) begin
    if (reset_i) begin
      rd_vld_q      <= 1'b0;
      rd_own_q      <= OWN_VID;
      vid_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      vid_rdata_q   <= '0;
      host_rdata_q  <= '0;
    end else begin
      rd_vld_q      <= rd_vld_d;
      rd_own_q      <= rd_own_d;
      vid_rvalid_q  <= vid_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
      vid_rdata_q   <= vid_rdata_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign vid_rvalid_o  = vid_rvalid_q;
  assign vid_rdata_o   = vid_rdata_q;
  assign host_rvalid_o = host_rvalid_q;
  assign host_rdata_o  = host_rdata_q;

endmodule

// File: rtl/sram_arbiter.sv
// Purpose: shares one async SRAM between video (read-only, priority) and host (read/write) with starvation guard.
// Latency: ack in N, SRAM access in N+1, read data returned in N+2; one access per cycle.
// Backpressure: requests are held until their ack; a write followed by a read costs one idle cycle.
// Ports: clk_core/reset; vid_req/vid_addr/vid_ack/vid_rvalid/vid_rdata (video client);
//   host_req/host_we/host_addr/host_wdata/host_ack/host_rvalid/host_rdata (host client);
//   sram_a/sram_wr/host_to_sram registered toward the pads, sram_to_host captured from the pads.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int MAX_VID_RUN   = 4,
  parameter int WR_TURNAROUND = 1
) (
  input  logic              clk_core,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] sram_a,
  output logic              sram_wr,
  output logic [DATA_W-1:0] host_to_sram,
  input  logic [DATA_W-1:0] sram_to_host
);

  localparam int SW = (MAX_VID_RUN < 1) ? 1 : $clog2(MAX_VID_RUN + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_VID_RUN);

  state_e            state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [ADDR_W-1:0] sram_a_q, sram_a_d;
  logic              sram_wr_q, sram_wr_d;
  logic [DATA_W-1:0] host_to_sram_q, host_to_sram_d;

  logic win_vid, win_host, win_rd, defer;
  logic grant_vid, grant_host, grant_any;

  // Arbitration: video wins ties until host has watched MAX_VID_RUN video grants go by.
  always_comb begin
    win_vid  = 1'b0;
    win_host = 1'b0;
    if (vid_req && host_req) begin
      if (starve_q == STARVE_MAX) win_host = 1'b1;
      else                        win_vid  = 1'b1;
    end else begin
      win_vid  = vid_req;
      win_host = host_req;
    end
    win_rd = win_vid || (win_host && !host_we);
    // A read may not follow a write directly on the bus: hold the ack one cycle and
    // let TURN take the grant while the SRAM sits idle.
    defer = (WR_TURNAROUND == 1) && (state_q == ACCESS) && sram_wr_q && win_rd;
    grant_vid  = win_vid  && !defer && !reset;
    grant_host = win_host && !defer && !reset;
    grant_any  = grant_vid || grant_host;
  end

  // Next-state: TURN accepts a grant in its own cycle, so a write->read costs exactly one idle cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = grant_any ? ACCESS : IDLE;
      ACCESS: begin
        if (grant_any)  state_d = ACCESS;
        else if (defer) state_d = TURN;
        else            state_d = IDLE;
      end
      TURN:    state_d = grant_any ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pad-side registers and starvation counter.
  always_comb begin
    sram_a_d       = sram_a_q;
    sram_wr_d      = 1'b0;
    host_to_sram_d = host_to_sram_q;
    starve_d       = starve_q;
    if (grant_vid) sram_a_d = vid_addr;
    if (grant_host) begin
      sram_a_d  = host_addr;
      sram_wr_d = host_we;
      if (host_we) host_to_sram_d = host_wdata;
    end
    if (!host_req || grant_host)                starve_d = '0;
    else if (grant_vid && starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk_core) begin
    if (reset) begin
      state_q        <= IDLE;
      starve_q       <= '0;
      sram_a_q       <= '0;
      sram_wr_q      <= 1'b0;
      host_to_sram_q <= '0;
    end else begin
      state_q        <= state_d;
      starve_q       <= starve_d;
      sram_a_q       <= sram_a_d;
      sram_wr_q      <= sram_wr_d;
      host_to_sram_q <= host_to_sram_d;
    end
  end

  sram_arb_return #(
    .DATA_W(DATA_W)
  ) u_return (
    .clk_core_i   (clk_core),
    .reset_i      (reset),
    .issue_rd_i   (grant_vid || (grant_host && !host_we)),
    .issue_own_i  (grant_host ? OWN_HOST : OWN_VID),
    .sram_rdata_i (sram_to_host),
    .vid_rvalid_o (vid_rvalid),
    .vid_rdata_o  (vid_rdata),
    .host_rvalid_o(host_rvalid),
    .host_rdata_o (host_rdata)
  );

  assign vid_ack      = grant_vid;
  assign host_ack     = grant_host;
  assign sram_a       = sram_a_q;
  assign sram_wr      = sram_wr_q;
  assign host_to_sram = host_to_sram_q;

endmodule
